// File: rtl/reg_file_32x32.sv
// 32-entry register bank with one-hot write select and two registered read ports.
// Multi-hot selects are dropped and flagged; reads bypass same-edge legal writes.
module reg_file_32x32 #(
    parameter int DATA_W   = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    output logic              wr_err
);

    logic [DATA_W-1:0] r_mem [32];
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;
    logic              r_valid;
    logic              r_err;

    logic              w_multi;
    logic [31:0]       w_wr_en;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // Multi-hot: clearing the lowest set bit still leaves a bit set
    assign w_multi = |(wr_sel & (wr_sel - 32'd1));

    // Per-entry write enable; illegal selects and the zero entry never write
    always_comb begin
        w_wr_en = w_multi ? 32'd0 : wr_sel;
        if (ZERO_REG) begin
            w_wr_en[0] = 1'b0;
        end
    end

    // Write-first read muxes: a legal same-edge write wins over storage
    always_comb begin
        w_rd_a = w_wr_en[rd_addr_a] ? wr_data : r_mem[rd_addr_a];
        w_rd_b = w_wr_en[rd_addr_b] ? wr_data : r_mem[rd_addr_b];
    end

    // Storage update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_wr_en[i]) begin
                    r_mem[i] <= wr_data;
                end
            end
        end
    end

    // Read output registers; data holds when no read is requested
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_en;
            if (rd_en) begin
                r_rd_a <= w_rd_a;
                r_rd_b <= w_rd_b;
            end
        end
    end

    // Error pulse follows each edge that sampled a multi-hot select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_multi;
        end
    end

    assign rd_data_a = r_rd_a;
    assign rd_data_b = r_rd_b;
    assign rd_valid  = r_valid;
    assign wr_err    = r_err;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Bench for reg_file_32x32: directed table, random traffic vs. array model,
// async reset mid-stream. Two instances cover ZERO_REG=1 and ZERO_REG=0.
module tb_reg_file_32x32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;

    logic [31:0] a1, b1, a0, b0;
    logic        v1, e1, v0, e0;

    int checks   = 0;
    int failures = 0;

    // model state: m1 for ZERO_REG=1, m0 for ZERO_REG=0
    logic [31:0] m1 [32];
    logic [31:0] m0 [32];
    logic [31:0] xa1, xb1, xa0, xb0;
    logic        xv, xe;

    always #5 clk = ~clk;

    reg_file_32x32 #(.DATA_W(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a1), .rd_data_b(b1), .rd_valid(v1), .wr_err(e1)
    );

    reg_file_32x32 #(.DATA_W(32), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a0), .rd_data_b(b0), .rd_valid(v0), .wr_err(e0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m1[i] = '0;
            m0[i] = '0;
        end
        xa1 = '0; xb1 = '0; xa0 = '0; xb0 = '0;
        xv = 1'b0; xe = 1'b0;
    endtask

    // Apply the rules for one edge to the model using the current inputs
    task automatic model_edge();
        int cnt;
        int widx;
        cnt  = $countones(wr_sel);
        widx = -1;
        for (int i = 0; i < 32; i++) begin
            if (wr_sel[i]) widx = i;
        end
        if (cnt != 1) widx = -1;
        xe = (cnt >= 2);
        xv = rd_en;
        if (rd_en) begin
            xa1 = (widx > 0 && widx == int'(rd_addr_a)) ? wr_data : m1[rd_addr_a];
            xb1 = (widx > 0 && widx == int'(rd_addr_b)) ? wr_data : m1[rd_addr_b];
            xa0 = (widx >= 0 && widx == int'(rd_addr_a)) ? wr_data : m0[rd_addr_a];
            xb0 = (widx >= 0 && widx == int'(rd_addr_b)) ? wr_data : m0[rd_addr_b];
        end
        if (widx > 0) m1[widx] = wr_data;
        if (widx >= 0) m0[widx] = wr_data;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_a_z1"}, a1, xa1);
        chk({tag, "_b_z1"}, b1, xb1);
        chk({tag, "_v_z1"}, 32'(v1), 32'(xv));
        chk({tag, "_err_z1"}, 32'(e1), 32'(xe));
        chk({tag, "_a_z0"}, a0, xa0);
        chk({tag, "_b_z0"}, b0, xb0);
        chk({tag, "_v_z0"}, 32'(v0), 32'(xv));
        chk({tag, "_err_z0"}, 32'(e0), 32'(xe));
    endtask

    // One clock: model predicts, edge happens, sample 1ns after it
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    task automatic drive(input logic [31:0] s, input logic [31:0] d,
                         input logic r, input logic [4:0] aa,
                         input logic [4:0] ab);
        wr_sel = s; wr_data = d; rd_en = r; rd_addr_a = aa; rd_addr_b = ab;
    endtask

    typedef struct {
        logic [31:0] sel;
        logic [31:0] data;
        logic        ren;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ev;
        logic        ee;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // expectations below are for the ZERO_REG=1 instance
        tbl[0]  = '{32'h0,       32'h0,         1, 5'd5,  5'd31, 32'h0,         32'h0,         1, 0};
        tbl[1]  = '{32'h8,       32'hDEAD_BEEF, 0, 5'd0,  5'd0,  32'h0,         32'h0,         0, 0};
        tbl[2]  = '{32'h0,       32'h0,         1, 5'd3,  5'd0,  32'hDEAD_BEEF, 32'h0,         1, 0};
        tbl[3]  = '{32'h1_0000,  32'h1234_5678, 1, 5'd16, 5'd16, 32'h1234_5678, 32'h1234_5678, 1, 0};
        tbl[4]  = '{32'h2,       32'hA,         0, 5'd0,  5'd0,  32'h1234_5678, 32'h1234_5678, 0, 0};
        tbl[5]  = '{32'h4,       32'hA,         0, 5'd0,  5'd0,  32'h1234_5678, 32'h1234_5678, 0, 0};
        tbl[6]  = '{32'h6,       32'hFFFF_FFFF, 1, 5'd1,  5'd2,  32'hA,         32'hA,         1, 1};
        tbl[7]  = '{32'h0,       32'h0,         1, 5'd1,  5'd2,  32'hA,         32'hA,         1, 0};
        tbl[8]  = '{32'h1,       32'h5555_5555, 1, 5'd0,  5'd3,  32'h0,         32'hDEAD_BEEF, 1, 0};
        tbl[9]  = '{32'h0,       32'h0,         0, 5'd0,  5'd0,  32'h0,         32'hDEAD_BEEF, 0, 0};
        tbl[10] = '{32'h6,       32'h0,         0, 5'd0,  5'd0,  32'h0,         32'hDEAD_BEEF, 0, 1};
        tbl[11] = '{32'h30,      32'h0,         0, 5'd0,  5'd0,  32'h0,         32'hDEAD_BEEF, 0, 1};
        tbl[12] = '{32'h0,       32'h0,         1, 5'd0,  5'd2,  32'h0,         32'hA,         1, 0};

        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_model("reset");
        #2;
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].sel, tbl[i].data, tbl[i].ren, tbl[i].aa, tbl[i].ab);
            tick($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_a", i), a1, tbl[i].ea);
            chk($sformatf("tbl%0d_b", i), b1, tbl[i].eb);
            chk($sformatf("tbl%0d_v", i), 32'(v1), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_err", i), 32'(e1), 32'(tbl[i].ee));
        end
        // same-edge write+read of entry 0 on the plain-register instance
        drive(32'h1, 32'h5555_5555, 1'b1, 5'd0, 5'd0);
        tick("z0_byp");
        chk("z0_byp_a", a0, 32'h5555_5555);
        chk("z1_byp_a", a1, 32'h0);

        // fill all 32 entries with unique patterns, then read back
        for (int i = 0; i < 32; i++) begin
            drive(32'h1 << i, 32'hC0DE_0000 | 32'(i * 32'h0101), 1'b0, 5'd0, 5'd0);
            tick($sformatf("fill%0d", i));
        end
        for (int i = 0; i < 32; i++) begin
            drive(32'h0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
            tick($sformatf("rdall%0d", i));
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int k;
            int x;
            int y;
            logic [31:0] s;
            k = $urandom_range(0, 9);
            x = $urandom_range(0, 31);
            y = (x + $urandom_range(1, 31)) % 32;
            if (k < 3)      s = 32'h0;
            else if (k < 8) s = 32'h1 << x;
            else            s = $urandom | (32'h1 << x) | (32'h1 << y);
            rd_en     = ($urandom_range(0, 3) != 0);
            rd_addr_a = ($urandom_range(0, 2) == 0) ? 5'(x) : 5'($urandom);
            rd_addr_b = ($urandom_range(0, 2) == 0) ? 5'(x) : 5'($urandom);
            wr_sel    = s;
            wr_data   = $urandom;
            tick($sformatf("rnd%0d", n));
        end

        // async reset between edges
        for (int i = 1; i < 6; i++) begin
            drive(32'h1 << i, 32'hBEEF_0000 | 32'(i), 1'b1, 5'(i), 5'(i));
            tick($sformatf("pre%0d", i));
        end
        drive(32'h6, 32'h0, 1'b1, 5'd1, 5'd2);
        tick("pre_err");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        cmp_model("async_rst");
        @(posedge clk);
        #3;
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd3, 5'd4);
        tick("post_hold0");
        tick("post_hold1");
        for (int i = 0; i < 32; i++) begin
            drive(32'h0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
            tick($sformatf("post_rd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

Thirty-two-entry register bank that consumes the 32-bit one-hot write-select vector produced by the 5-to-32 write decoder and stores write data into the selected entry. It provides two independent registered read ports for the operand-fetch stage. It also detects illegal multi-hot select vectors and suppresses the corrupt write.

## Interface
Parameters:
- DATA_W, 32, width of each register and of all data ports
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero (writes ignored, reads return 0); when 0 entry 0 is an ordinary register

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately on assertion
- wr_sel  input  32  one-hot write select from decoder; bit i selects entry i; all-zero means no write
- wr_data  input  DATA_W  data written to the selected entry
- rd_en  input  1  read request; sampled on rising edge
- rd_addr_a  input  5  read port A entry index
- rd_addr_b  input  5  read port B entry index
- rd_data_a  output  DATA_W  registered read data, port A
- rd_data_b  output  DATA_W  registered read data, port B
- rd_valid  output  1  high for one cycle when rd_data_a/b carry data for a read sampled on the previous edge
- wr_err  output  1  one-cycle pulse: the previous edge saw a multi-hot wr_sel

## Operation
- Storage: 32 entries × DATA_W bits.
- Write classification at each rising edge, from popcount of wr_sel:
  - 0: idle; no entry changes; no error.
  - 1 (bit i set): entry i <= wr_data. When ZERO_REG=1 and i=0, the write is discarded silently; no error.
  - ≥2: illegal; no entry changes; wr_err=1 for the following cycle.
- Read: when rd_en=1 at an edge, rd_data_a <= entry[rd_addr_a] and rd_data_b <= entry[rd_addr_b]; rd_valid <= 1.
- When rd_en=0: rd_data_a/b hold their previous values; rd_valid <= 0.
- Write-first bypass: if a legal write to entry i and a read of address i are sampled on the same edge, the read port returns the new wr_data, not the old contents. This applies to either or both ports.
- Bypass never applies to:
  - entry 0 when ZERO_REG=1 (returns 0);
  - an illegal multi-hot write (returns the old contents).
- Both ports may address the same entry; both return identical data.
- No internal state machine beyond storage and output registers. The block is fully pipelined, and a new read and a new write may be issued every cycle.

## Timing
- Write latency: the entry is updated at the edge where wr_sel is sampled. A read sampled at the next edge sees it; a read sampled at the same edge sees it via bypass.
- Read latency: 1 cycle. rd_en sampled at edge N gives rd_data_a/b and rd_valid=1 valid after edge N, stable until edge N+1.
- wr_err: registered; it asserts after the edge that sampled the multi-hot vector and deasserts after the next edge unless the illegal vector persists. Back-to-back illegal vectors hold wr_err high.
- Reset values: all 32 entries 0; rd_data_a=0; rd_data_b=0; rd_valid=0; wr_err=0.
- Reset mid-operation: clears immediately, independent of clk. A read or write sampled on an edge coincident with or during reset is lost.
- First edge after reset deasserts: operates normally; no warm-up cycle.
- No input back-pressure; the block never stalls.

## Test plan
- Reset then read: assert reset, release, rd_en=1 with addr_a=5 and addr_b=31 -> next cycle rd_data_a=0, rd_data_b=0, rd_valid=1, wr_err=0.
- Write then read: wr_sel=32'h0000_0008 with wr_data=32'hDEAD_BEEF; next cycle rd_en=1, addr_a=3 -> rd_data_a=32'hDEAD_BEEF one cycle later. Repeat for all 32 entries with a unique pattern each, then read all back.
- Bypass: same edge wr_sel=32'h0001_0000, wr_data=32'h1234_5678, rd_en=1, addr_a=16, addr_b=16 -> both ports=32'h1234_5678 next cycle.
- Illegal select: preload entries 1 and 2 with 32'hA, then wr_sel=32'h0000_0006 with wr_data=32'hFFFF_FFFF -> wr_err=1 for exactly one cycle; entries 1 and 2 still read 32'hA. Also check that wr_sel=0 causes no write and no error.
- ZERO_REG=1: wr_sel=32'h1 with wr_data=32'h5555_5555 plus a same-edge read of address 0 -> returns 0, wr_err=0. With ZERO_REG=0, the same stimulus returns 32'h5555_5555.
- Async reset mid-stream: write several entries, assert reset between clock edges -> all outputs 0 immediately, before any edge. After release, all entries read 0 and rd_data holds 0 while rd_en=0.
